// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-step controller that iterates an external single-step shifter
//
// Purpose: accepts one shift request per start handshake, then drives an
// external one-step shifter for `count` consecutive cycles. Each shifter
// output is fed back as the next cycle's input. The final word is returned
// on result together with a one-cycle done pulse.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   start, mode, count  request strobe, shift op (01 SRA1, 10 SLL8, else pass),
//                       and number of shifter steps
//   dataIn              operand sampled on accept
//   abort               cancels a request while it is running
//   ready, done         idle indicator, one-cycle completion pulse
//   result              last completed word, held until the next done
//   shifterControl/Data drive the external shifter
//   shifterOut          combinational shifter output
module shift_sequencer #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [WIDTH-1:0]       dataIn,
    input  logic                   abort,
    output logic                   ready,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic [1:0]             shifterControl,
    output logic [WIDTH-1:0]       shifterData,
    input  logic [WIDTH-1:0]       shifterOut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [1:0]             op_q, op_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]       result_q, result_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            op_q     <= 2'b00;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        op_d     = op_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d = dataIn;
                    op_d  = mode;
                    rem_d = count;
                    // Zero steps or a non-shifting op is a pass-through.
                    if (count == '0 || mode == 2'b00 || mode == 2'b11) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Abort beats the final step; acc keeps its partial value.
                    state_d = S_IDLE;
                end else begin
                    acc_d = shifterOut;
                    // RUN is only entered with rem >= 1 and left at 1, so the
                    // guard only matters for robustness; the counter never wraps.
                    if (rem_q != '0) begin
                        rem_d = rem_q - COUNT_WIDTH'(1);
                    end
                    if (rem_q == COUNT_WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                result_d = acc_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready          = (state_q == S_IDLE);
    assign done           = (state_q == S_DONE);
    assign result         = result_q;
    // The shifter only sees a shifting op while a request is running.
    assign shifterControl = (state_q == S_RUN) ? op_q : 2'b00;
    assign shifterData    = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  count;
    logic [31:0] dataIn;
    logic        abort;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic [1:0]  shifterControl;
    logic [31:0] shifterData;
    logic [31:0] shifterOut;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Reference single-step shifter outside the DUT.
    always_comb begin
        case (shifterControl)
            2'b01:   shifterOut = {shifterData[31], shifterData[31:1]};
            2'b10:   shifterOut = {shifterData[23:0], 8'h00};
            default: shifterOut = shifterData;
        endcase
    end

    shift_sequencer #(.WIDTH(32), .COUNT_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .count(count), .dataIn(dataIn), .abort(abort), .ready(ready),
        .done(done), .result(result), .shifterControl(shifterControl),
        .shifterData(shifterData), .shifterOut(shifterOut)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  count;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one request: checks latency, number of shifting cycles, result, ready.
    task automatic run_req(input string tag, input logic [1:0] m, input logic [4:0] c,
                           input logic [31:0] d, input logic [31:0] exp);
        int lat;
        int ctl_cycles;
        int exp_lat;
        int exp_ctl;
        bit pass;
        pass = (c == 5'd0) || (m == 2'b00) || (m == 2'b11);
        exp_lat = pass ? 1 : int'(c) + 1;
        exp_ctl = pass ? 0 : int'(c);
        @(negedge clock);
        check({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
        start = 1'b1; mode = m; count = c; dataIn = d;
        @(posedge clock);
        #1 start = 1'b0;
        lat = 0;
        ctl_cycles = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clock);
            if (shifterControl != 2'b00) ctl_cycles++;
            if (shifterControl != 2'b00 && shifterControl != m)
                check({tag, "_ctl_value"}, {30'd0, shifterControl}, {30'd0, m});
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_ctl_cycles"}, ctl_cycles, exp_ctl);
        @(negedge clock);
        check({tag, "_result"}, result, exp);
        check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
        check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        vt[0] = '{2'b01, 5'd3,  32'h80000000, 32'hF0000000};
        vt[1] = '{2'b10, 5'd2,  32'h000000AB, 32'h00AB0000};
        vt[2] = '{2'b10, 5'd5,  32'hFFFFFFFF, 32'h00000000};
        vt[3] = '{2'b01, 5'd0,  32'h12345678, 32'h12345678};
        vt[4] = '{2'b11, 5'd7,  32'h12345678, 32'h12345678};
        vt[5] = '{2'b00, 5'd9,  32'h12345678, 32'h12345678};
        vt[6] = '{2'b01, 5'd31, 32'h80000000, 32'hFFFFFFFF};
        vt[7] = '{2'b01, 5'd31, 32'h7FFFFFFF, 32'h00000000};
        vt[8] = '{2'b01, 5'd1,  32'h88888888, 32'hC4444444};

        reset = 1'b0; start = 1'b0; mode = 2'b00; count = 5'd0;
        dataIn = 32'h0; abort = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_ctl", {30'd0, shifterControl}, 32'd0);
        check("rst_sdata", shifterData, 32'h0);

        for (int i = 0; i < 9; i++) begin
            run_req($sformatf("vec%0d", i), vt[i].mode, vt[i].count, vt[i].din, vt[i].exp);
        end

        // Abort on the 4th RUN cycle; a start during RUN must be ignored.
        @(negedge clock);
        start = 1'b1; mode = 2'b01; count = 5'd10; dataIn = 32'h80000000;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);                       // RUN cycle 1
        check("abort_ready_in_run", {31'd0, ready}, 32'd0);
        start = 1'b1; dataIn = 32'h00000001; mode = 2'b10; count = 5'd1;
        @(negedge clock);                       // RUN cycle 2
        start = 1'b0;
        @(negedge clock);                       // RUN cycle 3
        @(negedge clock);                       // RUN cycle 4
        check("abort_ctl_in_run", {30'd0, shifterControl}, 32'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_ctl_idle", {30'd0, shifterControl}, 32'd0);
        check("abort_partial_acc", shifterData, 32'hF0000000);
        done_seen = (done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_result_held", result, 32'hC4444444);

        // Reset in the middle of RUN.
        @(negedge clock);
        start = 1'b1; mode = 2'b10; count = 5'd8; dataIn = 32'h00000001;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        check("rrun_ctl_in_run", {30'd0, shifterControl}, 32'd2);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("rrun_ready", {31'd0, ready}, 32'd1);
        check("rrun_done", {31'd0, done}, 32'd0);
        check("rrun_result", result, 32'h0);
        check("rrun_ctl", {30'd0, shifterControl}, 32'd0);
        check("rrun_sdata", shifterData, 32'h0);
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (done === 1'b1) done_seen++;
        end
        check("rrun_no_done", done_seen, 0);
        run_req("after_rst", 2'b01, 5'd2, 32'h80000000, 32'hE0000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-step controller for the single-step MIC-1 shifter (control 00 = pass, 01 = arithmetic right shift by 1, 10 = logical left shift by 8). It accepts one shift request per handshake, drives the shifter's control and data inputs for N consecutive cycles, and feeds each shifter output back as the next cycle's input. It returns the final word with a one-cycle done pulse. It sits between the microsequencer and the shifter, which is instantiated outside this block.

Parameters:
WIDTH, 32, datapath width; must match the shifter.
COUNT_WIDTH, 5, width of the step-count field; maximum steps = 2^COUNT_WIDTH - 1.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset.
start  input  1  request strobe; accepted only when ready = 1.
mode  input  2  shift operation for the request: 01 SRA1, 10 SLL8, 00/11 pass.
count  input  COUNT_WIDTH  number of shifter steps to apply.
dataIn  input  WIDTH  operand sampled on accept.
abort  input  1  cancels an in-progress request.
ready  output  1  high in IDLE only.
done  output  1  one-cycle pulse when result updates.
result  output  WIDTH  final shifted word; holds its value until the next done.
shifterControl  output  2  drives the shifter control input.
shifterData  output  WIDTH  drives the shifter data input.
shifterOut  input  WIDTH  shifter dataOut, combinational from shifterControl/shifterData.

Behaviour:
- One clock domain. Reset is synchronous and active-low: sampled on the rising clock edge, and takes priority over all other inputs.
- Reset values: state = IDLE, ready = 1, done = 0, result = 0, shifterControl = 00, shifterData = 0. The internal accumulator (acc) and remaining counter reset to 0.
- States: IDLE, RUN, DONE, encoded in 2 bits. The unused encoding returns to IDLE.
- IDLE transitions:
  - On start = 1: acc <= dataIn, op <= mode, remaining <= count.
  - If count = 0 or mode is 00/11: go to DONE (pass-through).
  - Otherwise go to RUN.
  - start = 0: stay in IDLE.
- RUN behaviour:
  - shifterControl = op and shifterData = acc, both combinational from registers.
  - Each edge: acc <= shifterOut, remaining <= remaining - 1.
  - When remaining = 1 at the edge, go to DONE.
  - Exactly `count` shifter steps are applied.
- DONE behaviour: result <= acc, done = 1 for this cycle only, shifterControl = 00. Next state is IDLE.
- Latency: if start is accepted at edge E0, done is high during the cycle after edge E(count), i.e. count+1 cycles after accept. With count = 0, done is high in the cycle after E0.
- Outside RUN: shifterControl = 00 and shifterData = acc. The shifter is never left in a shifting mode while idle.
- abort:
  - Ignored in IDLE and DONE.
  - In RUN it forces IDLE at the next edge: no done pulse, result unchanged, acc keeps its partial value.
  - abort and the final RUN step in the same cycle: abort wins.
- start while not ready is ignored; it is not queued.
- The block performs no arithmetic of its own beyond the count decrement. The remaining counter never wraps.
- Left shift saturates naturally: 4 or more SLL8 steps yield 0. Right shift saturates to all sign bits after WIDTH-1 steps. These are the correct results, not errors.
- Reset asserted mid-RUN: return to reset values at that edge, drop the request, no done pulse.

Test Plan:
- Reset held 2 cycles, then released -> ready = 1, done = 0, result = 0x00000000, shifterControl = 00.
- dataIn = 0x88888888, mode = 01, count = 1 -> shifterControl = 01 for exactly one cycle; done one cycle later with result = 0xC4444444; ready back to 1 the following cycle.
- dataIn = 0x80000000, mode = 01, count = 3 -> done 4 cycles after accept, result = 0xF0000000. Then dataIn = 0x000000AB, mode = 10, count = 2 -> result = 0x00AB0000. Then mode = 10, count = 5 on 0xFFFFFFFF -> result = 0x00000000.
- count = 0 (any mode), or mode = 11 with count = 7, on dataIn = 0x12345678 -> done in the next cycle, result = 0x12345678, shifterControl stays 00 throughout.
- mode = 01, count = 10 started with result previously 0xC4444444; assert abort on the 4th RUN cycle -> no done pulse, result stays 0xC4444444, ready = 1 next cycle. A start pulsed during RUN is ignored (no second done).
- reset = 0 during RUN (count = 8) -> all outputs at reset values after that edge, no done. A fresh request afterwards completes with correct latency and value.
